hilo_muldiv_ctrl: RTL and testbench

HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

---
 rtl/hilo_muldiv_ctrl.sv | 146 ++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide on magnitudes,
// with sign fix-up, mthi/mtlo writes and a pipeline stall request.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  input  logic        hilo_rd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_reg;
  logic [4:0]  count_reg;
  logic        is_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [31:0] divisor_reg;
  logic [31:0] work_hi_reg;
  logic [31:0] work_lo_reg;

  // op[0] clear selects the signed variants (MULT, DIV)
  logic        signed_op;
  logic        div_by_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign signed_op   = ~op[0];
  assign div_by_zero = op[1] && (rt_val == 32'd0);
  assign mag_a       = (signed_op && rs_val[31]) ? -rs_val : rs_val;
  assign mag_b       = (signed_op && rt_val[31]) ? -rt_val : rt_val;

  logic [32:0] mul_sum;
  logic [31:0] mul_hi_next;
  logic [31:0] mul_lo_next;
  logic [32:0] div_part;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [31:0] div_hi_next;
  logic [31:0] div_lo_next;
  logic [63:0] prod_fixed;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    mul_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, divisor_reg} : 33'd0);
    mul_hi_next = mul_sum[32:1];
    mul_lo_next = {mul_sum[0], work_lo_reg[31:1]};

    // Partial remainder is always below the divisor, so the difference fits in 32 bits
    div_part    = {work_hi_reg, work_lo_reg[31]};
    div_ge      = div_part >= {1'b0, divisor_reg};
    div_diff    = div_part[31:0] - divisor_reg;
    div_hi_next = div_ge ? div_diff : div_part[31:0];
    div_lo_next = {work_lo_reg[30:0], div_ge};

    prod_fixed  = neg_q_reg ? -{work_hi_reg, work_lo_reg} : {work_hi_reg, work_lo_reg};
    if (is_div_reg) begin
      fix_lo = neg_q_reg ? -work_lo_reg : work_lo_reg;
      fix_hi = neg_r_reg ? -work_hi_reg : work_hi_reg;
    end else begin
      fix_hi = prod_fixed[63:32];
      fix_lo = prod_fixed[31:0];
    end
  end

  assign stall = (busy & (start | mthi | mtlo | hilo_rd)) | (~busy & start & (mthi | mtlo));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= 5'd0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      divisor_reg <= 32'd0;
      work_hi_reg <= 32'd0;
      work_lo_reg <= 32'd0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (div_by_zero) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              is_div_reg  <= op[1];
              neg_q_reg   <= signed_op & (rs_val[31] ^ rt_val[31]);
              neg_r_reg   <= signed_op & op[1] & rs_val[31];
              divisor_reg <= mag_b;
              work_hi_reg <= 32'd0;
              work_lo_reg <= mag_a;
              count_reg   <= 5'd0;
              div_zero    <= 1'b0;
              busy        <= 1'b1;
              state_reg   <= CALC;
            end
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        CALC: begin
          if (is_div_reg) begin
            work_hi_reg <= div_hi_next;
            work_lo_reg <= div_lo_next;
          end else begin
            work_hi_reg <= mul_hi_next;
            work_lo_reg <= mul_lo_next;
          end
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) state_reg <= FIX;
        end
        FIX: begin
          hi        <= fix_hi;
          lo        <= fix_lo;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized and directed bench for hilo_muldiv_ctrl against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, mthi, mtlo, hilo_rd;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, mt_data;
  logic [31:0] hi, lo;
  logic        busy, done, stall, div_zero;

  hilo_muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .mt_data(mt_data), .hilo_rd(hilo_rd), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall), .div_zero(div_zero)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: result is pending for m_rem more edges after acceptance
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic        m_done = 0, m_dz = 0;
  int          m_rem = 0;

  function automatic logic [63:0] model_result(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f_op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(a % b), 32'(a / b)};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic model_edge();
    logic [63:0] r;
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_done = 0; m_dz = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
        end
      end else if (start) begin
        if (op[1] && rt_val == 0) begin
          m_dz = 1; m_done = 1;
        end else begin
          r = model_result(op, rs_val, rt_val);
          p_hi = r[63:32]; p_lo = r[31:0];
          m_dz = 0; m_rem = 33;
        end
      end else begin
        if (mthi) m_hi = mt_data;
        if (mtlo) m_lo = mt_data;
      end
    end
  endtask

  // One clock: check stall for the current inputs, clock, then check registered outputs
  task automatic step();
    logic mb;
    #1;
    mb = (m_rem > 0);
    chk("stall", stall, (mb & (start | mthi | mtlo | hilo_rd)) | (~mb & start & (mthi | mtlo)));
    @(posedge clk);
    model_edge();
    #1;
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", busy, m_rem > 0);
    chk("done", done, m_done);
    chk("div_zero", div_zero, m_dz);
  endtask

  task automatic run_op(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    int i;
    op = f_op; rs_val = a; rt_val = b; start = 1;
    step();
    start = 0;
    rs_val = $urandom; rt_val = $urandom;
    i = 0;
    while (!m_done && i < 40) begin
      step();
      i++;
    end
    chk("op_timeout", m_done, 1);
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h dz=%0d", f_op, a, b, hi, lo, div_zero);
  endtask

  initial begin
    rst_n = 0; start = 0; op = 0; rs_val = 0; rt_val = 0;
    mthi = 0; mtlo = 0; mt_data = 0; hilo_rd = 0;
    @(posedge clk);
    model_edge();
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", div_zero, 0);
    step();
    rst_n = 1;

    chk("model_mult", model_result(2'b00, 32'hFFFFFFFE, 32'd3), 64'hFFFFFFFF_FFFFFFFA);
    chk("model_multu", model_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    chk("model_mult_min", model_result(2'b00, 32'h80000000, 32'h80000000), 64'h40000000_00000000);
    chk("model_div", model_result(2'b10, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_divu", model_result(2'b11, 32'd7, 32'd2), 64'h00000001_00000003);
    chk("model_div_ovf", model_result(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    run_op(2'b00, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    chk("mult_done", done, 1);
    chk("mult_busy", busy, 0);
    step();
    chk("mult_done_once", done, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    run_op(2'b00, 32'h80000000, 32'h80000000);
    chk("mult_min_hi", hi, 32'h40000000);
    chk("mult_min_lo", lo, 32'h0);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(2'b11, 32'd7, 32'd2);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);

    // Divide by zero leaves HI/LO untouched and never raises busy
    mthi = 1; mt_data = 32'h12; step();
    mthi = 0; mtlo = 1; mt_data = 32'h34; step();
    mtlo = 0;
    run_op(2'b11, 32'd99, 32'd0);
    chk("dz_done", done, 1);
    chk("dz_flag", div_zero, 1);
    chk("dz_hi", hi, 32'h12);
    chk("dz_lo", lo, 32'h34);
    chk("dz_busy", busy, 0);
    step();
    chk("dz_sticky", div_zero, 1);

    // Reads and mthi held while busy: stall every busy cycle, write lands once idle
    op = 2'b01; rs_val = 32'h10; rt_val = 32'h20; start = 1;
    step();
    start = 0; mthi = 1; hilo_rd = 1; mt_data = 32'hAAAA5555;
    for (int i = 0; i < 40 && !m_done; i++) begin
      #1;
      if (m_rem > 0) chk("stall_busy", stall, 1);
      step();
    end
    chk("hold_hi", hi, 32'h0);
    chk("hold_lo", lo, 32'h200);
    step();
    chk("hold_mthi", hi, 32'hAAAA5555);
    mthi = 0; hilo_rd = 0;
    $display("mthi during busy -> hi=%h lo=%h", hi, lo);

    // Reset at count=10 aborts the op, then a fresh op is accepted right away
    op = 2'b00; rs_val = 32'd123; rt_val = 32'd456; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 0;
    step();
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst_n = 1;
    run_op(2'b01, 32'd5, 32'd6);
    chk("fresh_lo", lo, 32'd30);
    chk("fresh_hi", hi, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 399) != 0);
      start   = ($urandom_range(0, 7) == 0);
      op      = 2'($urandom);
      rs_val  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: rt_val = 32'd0;
        1: rt_val = 32'hFFFFFFFF;
        2: rt_val = $urandom_range(1, 9);
        default: rt_val = $urandom;
      endcase
      mthi    = ($urandom_range(0, 3) == 0);
      mtlo    = ($urandom_range(0, 3) == 0);
      mt_data = $urandom;
      hilo_rd = $urandom_range(0, 1);
      step();
      if (m_done) $display("random cycle %0d: done hi=%h lo=%h dz=%0d", i, hi, lo, div_zero);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
